// File: rtl/alu_arbiter.sv
// Round-robin valid/ready arbiter sharing one combinational Alu between two requesters.
// Holds a lock for division chains, owns the DI feedback register and registers results.
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int LOCK_MAX = 34
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_VALID0,
  input  logic             REQ_VALID1,
  output logic             REQ_READY0,
  output logic             REQ_READY1,
  input  logic [3:0]       REQ_INST0,
  input  logic [3:0]       REQ_INST1,
  input  logic [WIDTH-1:0] REQ_A0,
  input  logic [WIDTH-1:0] REQ_A1,
  input  logic [WIDTH-1:0] REQ_B0,
  input  logic [WIDTH-1:0] REQ_B1,
  input  logic             REQ_CI0,
  input  logic             REQ_CI1,
  input  logic             REQ_LOCK0,
  input  logic             REQ_LOCK1,
  output logic             RSP_VALID0,
  output logic             RSP_VALID1,
  output logic [WIDTH-1:0] RSP_Z,
  output logic [3:0]       RSP_FLAGS,
  output logic             LOCK_ERR,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [WIDTH-1:0] ALU_DI,
  output logic [3:0]       ALU_INST,
  output logic             ALU_CI,
  output logic             ALU_FIRST,
  input  logic [WIDTH-1:0] ALU_Z,
  input  logic [WIDTH-1:0] ALU_DO,
  input  logic [3:0]       ALU_FLAGS
);

  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0] LCNT_ONE = LCW'(1);
  localparam logic [LCW-1:0] LCNT_MAX = LCW'(LOCK_MAX);
  localparam logic [3:0] INST_DIV  = 4'd6;
  localparam logic [3:0] INST_ZERO = 4'd14;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic             r_chain;
  logic [WIDTH-1:0] r_di;
  logic [LCW-1:0]   r_lcnt;
  logic             r_rsp_valid0;
  logic             r_rsp_valid1;
  logic [WIDTH-1:0] r_rsp_z;
  logic [3:0]       r_rsp_flags;
  logic             r_lock_err;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer;
  logic             w_lock;
  logic [LCW-1:0]   w_lcnt_inc;
  logic             w_force;
  logic             w_keep_lock;

  // Grant selection: depends only on registered state and the VALIDs.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      UNLOCKED: begin
        w_gnt0 = REQ_VALID0 && (!REQ_VALID1 || r_last);
        w_gnt1 = REQ_VALID1 && (!REQ_VALID0 || !r_last);
      end
      LOCK0: begin
        w_gnt0 = REQ_VALID0;
        w_gnt1 = 1'b0;
      end
      LOCK1: begin
        w_gnt0 = 1'b0;
        w_gnt1 = REQ_VALID1;
      end
      default: begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
      end
    endcase
  end

  // Alu operand mux; an idle Alu is parked on the zero instruction.
  always_comb begin
    ALU_A    = '0;
    ALU_B    = '0;
    ALU_INST = INST_ZERO;
    ALU_CI   = 1'b0;
    w_lock   = 1'b0;
    if (w_gnt0) begin
      ALU_A    = REQ_A0;
      ALU_B    = REQ_B0;
      ALU_INST = REQ_INST0;
      ALU_CI   = REQ_CI0;
      w_lock   = REQ_LOCK0;
    end else if (w_gnt1) begin
      ALU_A    = REQ_A1;
      ALU_B    = REQ_B1;
      ALU_INST = REQ_INST1;
      ALU_CI   = REQ_CI1;
      w_lock   = REQ_LOCK1;
    end else begin
      ALU_A    = '0;
      ALU_B    = '0;
      ALU_INST = INST_ZERO;
      ALU_CI   = 1'b0;
      w_lock   = 1'b0;
    end
  end

  // Lock-beat count restarts at one when a lock is taken from UNLOCKED.
  always_comb begin
    if (r_state == UNLOCKED) begin
      w_lcnt_inc = LCNT_ONE;
    end else begin
      w_lcnt_inc = r_lcnt + LCNT_ONE;
    end
  end

  assign w_xfer      = w_gnt0 || w_gnt1;
  assign w_force     = w_xfer && w_lock && (w_lcnt_inc >= LCNT_MAX);
  assign w_keep_lock = w_lock && !w_force;

  assign REQ_READY0 = w_gnt0;
  assign REQ_READY1 = w_gnt1;
  assign ALU_DI     = r_di;
  assign ALU_FIRST  = (ALU_INST == INST_DIV) && !r_chain;

  // Arbitration state, lock counter and division feedback register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= UNLOCKED;
      r_last  <= 1'b1;
      r_chain <= 1'b0;
      r_di    <= '0;
      r_lcnt  <= '0;
    end else if (w_xfer) begin
      r_last <= w_gnt1;
      if (ALU_INST == INST_DIV) begin
        r_di    <= ALU_DO;
        r_chain <= w_keep_lock;
      end else begin
        r_chain <= 1'b0;
      end
      if (w_keep_lock) begin
        r_state <= w_gnt1 ? LOCK1 : LOCK0;
        r_lcnt  <= w_lcnt_inc;
      end else begin
        r_state <= UNLOCKED;
        r_lcnt  <= '0;
      end
    end
  end

  // Registered response; Z and flags hold between transfers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_rsp_z      <= '0;
      r_rsp_flags  <= 4'd0;
      r_lock_err   <= 1'b0;
    end else begin
      r_rsp_valid0 <= w_gnt0;
      r_rsp_valid1 <= w_gnt1;
      r_lock_err   <= w_force;
      if (w_xfer) begin
        r_rsp_z     <= ALU_Z;
        r_rsp_flags <= ALU_FLAGS;
      end
    end
  end

  assign RSP_VALID0 = r_rsp_valid0;
  assign RSP_VALID1 = r_rsp_valid1;
  assign RSP_Z      = r_rsp_z;
  assign RSP_FLAGS  = r_rsp_flags;
  assign LOCK_ERR   = r_lock_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Table-driven bench for alu_arbiter with a stand-in Alu and a response scoreboard.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID0, REQ_VALID1, REQ_READY0, REQ_READY1;
  logic [3:0]  REQ_INST0, REQ_INST1;
  logic [31:0] REQ_A0, REQ_A1, REQ_B0, REQ_B1;
  logic        REQ_CI0, REQ_CI1, REQ_LOCK0, REQ_LOCK1;
  logic        RSP_VALID0, RSP_VALID1, LOCK_ERR;
  logic [31:0] RSP_Z, ALU_A, ALU_B, ALU_DI, ALU_Z, ALU_DO;
  logic [3:0]  RSP_FLAGS, ALU_INST, ALU_FLAGS;
  logic        ALU_CI, ALU_FIRST;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(32), .LOCK_MAX(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID0(REQ_VALID0), .REQ_VALID1(REQ_VALID1),
    .REQ_READY0(REQ_READY0), .REQ_READY1(REQ_READY1),
    .REQ_INST0(REQ_INST0), .REQ_INST1(REQ_INST1),
    .REQ_A0(REQ_A0), .REQ_A1(REQ_A1), .REQ_B0(REQ_B0), .REQ_B1(REQ_B1),
    .REQ_CI0(REQ_CI0), .REQ_CI1(REQ_CI1),
    .REQ_LOCK0(REQ_LOCK0), .REQ_LOCK1(REQ_LOCK1),
    .RSP_VALID0(RSP_VALID0), .RSP_VALID1(RSP_VALID1),
    .RSP_Z(RSP_Z), .RSP_FLAGS(RSP_FLAGS), .LOCK_ERR(LOCK_ERR),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_DI(ALU_DI),
    .ALU_INST(ALU_INST), .ALU_CI(ALU_CI), .ALU_FIRST(ALU_FIRST),
    .ALU_Z(ALU_Z), .ALU_DO(ALU_DO), .ALU_FLAGS(ALU_FLAGS)
  );

  // Stand-in Alu: 0 = A+1, 2 = A+B+CI, 6 = division step on (first ? A : DI)+B, else Z=0.
  function automatic logic [67:0] alu_f(input logic [3:0] inst, input logic [31:0] a, b,
                                        input logic ci, input logic [31:0] di, input logic first);
    logic [32:0] s;
    logic [31:0] oa, ob;
    logic        act, ovf;
    act = 1'b1; oa = a; ob = b;
    case (inst)
      4'd0: begin ob = 32'd1; s = {1'b0, a} + 33'd1; end
      4'd2: s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      4'd6: begin oa = first ? a : di; s = {1'b0, oa} + {1'b0, b}; end
      default: begin act = 1'b0; s = 33'd0; end
    endcase
    ovf = act && (oa[31] == ob[31]) && (s[31] != oa[31]);
    return {1'b0, s[31:0] == 32'd0, s[32], ovf, s[31:0],
            (inst == 4'd6) ? (s[31:0] ^ 32'd1) : 32'd0};
  endfunction

  always_comb {ALU_FLAGS, ALU_Z, ALU_DO} = alu_f(ALU_INST, ALU_A, ALU_B, ALU_CI, ALU_DI, ALU_FIRST);

  typedef struct {
    logic v; logic [3:0] inst; logic [31:0] a, b; logic ci, lock;
  } op_t;
  typedef struct {
    op_t o0, o1; logic r0, r1, first, lerr;
  } vec_t;
  typedef struct {
    logic [1:0] who; logic [31:0] z; logic [3:0] fl;
  } rsp_t;

  vec_t  vecs[$];
  rsp_t  sb[$];
  int    n_checks = 0;
  int    n_err    = 0;
  logic [31:0] tb_di;

  function automatic op_t mkop(input logic v, input logic [3:0] inst, input logic [31:0] a, b,
                               input logic ci, input logic lock);
    op_t o;
    o.v = v; o.inst = inst; o.a = a; o.b = b; o.ci = ci; o.lock = lock;
    return o;
  endfunction

  function automatic vec_t mkv(input op_t o0, o1, input logic r0, r1, first, lerr);
    vec_t t;
    t.o0 = o0; t.o1 = o1; t.r0 = r0; t.r1 = r1; t.first = first; t.lerr = lerr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    REQ_VALID0 = 1'b0; REQ_INST0 = 4'd0; REQ_A0 = 32'd0; REQ_B0 = 32'd0; REQ_CI0 = 1'b0; REQ_LOCK0 = 1'b0;
    REQ_VALID1 = 1'b0; REQ_INST1 = 4'd0; REQ_A1 = 32'd0; REQ_B1 = 32'd0; REQ_CI1 = 1'b0; REQ_LOCK1 = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] who, input op_t o, input logic first);
    logic [67:0] r;
    rsp_t e;
    r = alu_f(o.inst, o.a, o.b, o.ci, tb_di, first);
    e.who = who; e.z = r[63:32]; e.fl = r[67:64];
    sb.push_back(e);
    if (o.inst == 4'd6) tb_di = r[31:0];
  endtask

  // Called at posedge+1: check last cycle's response, drive, check comb outputs, advance.
  task automatic apply(input vec_t t, input int idx);
    rsp_t e;
    logic [3:0] exp_inst;
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.who = 2'b00; e.z = 32'd0; e.fl = 4'd0; end
    chk($sformatf("v%0d rsp_valid", idx), {30'd0, RSP_VALID1, RSP_VALID0}, {30'd0, e.who});
    if (e.who != 2'b00) begin
      chk($sformatf("v%0d rsp_z", idx), RSP_Z, e.z);
      chk($sformatf("v%0d rsp_flags", idx), {28'd0, RSP_FLAGS}, {28'd0, e.fl});
    end
    chk($sformatf("v%0d lock_err", idx), {31'd0, LOCK_ERR}, {31'd0, t.lerr});
    REQ_VALID0 = t.o0.v; REQ_INST0 = t.o0.inst; REQ_A0 = t.o0.a; REQ_B0 = t.o0.b;
    REQ_CI0 = t.o0.ci; REQ_LOCK0 = t.o0.lock;
    REQ_VALID1 = t.o1.v; REQ_INST1 = t.o1.inst; REQ_A1 = t.o1.a; REQ_B1 = t.o1.b;
    REQ_CI1 = t.o1.ci; REQ_LOCK1 = t.o1.lock;
    #1;
    exp_inst = t.r0 ? t.o0.inst : (t.r1 ? t.o1.inst : 4'd14);
    chk($sformatf("v%0d ready", idx), {30'd0, REQ_READY1, REQ_READY0}, {30'd0, t.r1, t.r0});
    chk($sformatf("v%0d alu_first", idx), {31'd0, ALU_FIRST}, {31'd0, t.first});
    chk($sformatf("v%0d alu_di", idx), ALU_DI, tb_di);
    chk($sformatf("v%0d alu_inst", idx), {28'd0, ALU_INST}, {28'd0, exp_inst});
    if (t.r0 && t.o0.v) push_exp(2'b01, t.o0, t.first);
    else if (t.r1 && t.o1.v) push_exp(2'b10, t.o1, t.first);
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t idle, r1v;
    idle = mkop(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    r1v  = mkop(1'b1, 4'd0, 32'h0000_0020, 32'd0, 1'b0, 1'b0);
    // Contention after reset, then a single add
    vecs.push_back(mkv(mkop(1, 4'd0, 32'd5, 32'd0, 0, 0), mkop(1, 4'd0, 32'hFFFF_FFFF, 32'd0, 0, 0), 1, 0, 0, 0));
    vecs.push_back(mkv(mkop(1, 4'd0, 32'd5, 32'd0, 0, 0), mkop(1, 4'd0, 32'hFFFF_FFFF, 32'd0, 0, 0), 0, 1, 0, 0));
    vecs.push_back(mkv(mkop(1, 4'd2, 32'd1, 32'd1, 0, 0), idle, 1, 0, 0, 0));
    vecs.push_back(mkv(idle, idle, 0, 0, 0, 0));
    // Division chain on requester 1 with requester 0 waiting
    vecs.push_back(mkv(mkop(1, 4'd2, 32'd3, 32'd4, 0, 0), mkop(1, 4'd6, 32'd100, 32'd7, 0, 1), 0, 1, 1, 0));
    vecs.push_back(mkv(mkop(1, 4'd2, 32'd3, 32'd4, 0, 0), mkop(1, 4'd6, 32'd100, 32'd7, 0, 1), 0, 1, 0, 0));
    vecs.push_back(mkv(mkop(1, 4'd2, 32'd3, 32'd4, 0, 0), mkop(1, 4'd6, 32'd100, 32'd9, 0, 1), 0, 1, 0, 0));
    vecs.push_back(mkv(mkop(1, 4'd2, 32'd3, 32'd4, 0, 0), mkop(1, 4'd6, 32'd100, 32'd11, 0, 0), 0, 1, 0, 0));
    vecs.push_back(mkv(mkop(1, 4'd2, 32'd3, 32'd4, 0, 0), mkop(1, 4'd2, 32'd9, 32'd1, 1, 0), 1, 0, 0, 0));
    vecs.push_back(mkv(idle, mkop(1, 4'd2, 32'd9, 32'd1, 1, 0), 0, 1, 0, 0));
    // Lock held by an idle owner, then release and non-owner wins
    vecs.push_back(mkv(mkop(1, 4'd2, 32'd10, 32'd20, 0, 1), r1v, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(idle, r1v, 0, 0, 0, 0));
    vecs.push_back(mkv(mkop(1, 4'd2, 32'h7FFF_FFFF, 32'd1, 0, 0), r1v, 1, 0, 0, 0));
    vecs.push_back(mkv(mkop(1, 4'd2, 32'd1, 32'd2, 0, 0), r1v, 0, 1, 0, 0));
    // Forced unlock after LOCK_MAX=4 locked beats
    vecs.push_back(mkv(mkop(1, 4'd6, 32'd50, 32'd3, 0, 1), r1v, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(mkop(1, 4'd6, 32'd50, 32'd3, 0, 1), r1v, 1, 0, 0, 0));
    vecs.push_back(mkv(mkop(1, 4'd6, 32'd50, 32'd3, 0, 1), r1v, 0, 1, 0, 1));
    vecs.push_back(mkv(mkop(1, 4'd6, 32'd60, 32'd5, 0, 1), idle, 1, 0, 1, 0));
    vecs.push_back(mkv(mkop(1, 4'd6, 32'd60, 32'd5, 0, 1), idle, 1, 0, 0, 0));

    drive_idle();
    tb_di = 32'd0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset rsp_valid", {30'd0, RSP_VALID1, RSP_VALID0}, 32'd0);
    chk("reset rsp_z", RSP_Z, 32'd0);
    chk("reset rsp_flags", {28'd0, RSP_FLAGS}, 32'd0);
    chk("reset lock_err", {31'd0, LOCK_ERR}, 32'd0);
    chk("reset alu_di", ALU_DI, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset between two locked op6 beats: pending response and di are discarded
    drive_idle();
    RST_N = 1'b0;
    #1;
    chk("midrst rsp_valid", {30'd0, RSP_VALID1, RSP_VALID0}, 32'd0);
    chk("midrst rsp_z", RSP_Z, 32'd0);
    chk("midrst alu_di", ALU_DI, 32'd0);
    sb.delete();
    tb_di = 32'd0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    apply(mkv(mkop(1, 4'd6, 32'd77, 32'd2, 0, 1), r1v, 1, 0, 1, 0), 100);
    apply(mkv(idle, idle, 0, 0, 0, 0), 101);
    apply(mkv(idle, idle, 0, 0, 0, 0), 102);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
